// File: rtl/fasta_feeder_pkg.sv
// fasta_feeder shared types: FSM states, ASCII constants, base encoding.
// encode() maps an ASCII nucleotide to its 2-bit aligner code.
package fasta_feeder_pkg;

   typedef enum logic [2:0] {
      Q_HDR,
      Q_SEQ,
      DB_HDR,
      DB_SEQ,
      DRAIN,
      REPORT,
      FLUSH,
      DONE
   } state_t;

   localparam logic [7:0] CH_LF = 8'h0A;
   localparam logic [7:0] CH_CR = 8'h0D;
   localparam logic [7:0] CH_GT = 8'h3E;

   typedef logic [1:0] base_t;

   typedef struct packed {
      logic  vld;
      base_t b;
   } enc_t;

   function automatic enc_t encode(input logic [7:0] c);
      enc_t e;
      e.vld = 1'b1;
      e.b   = 2'b00;
      case (c)
         8'h41, 8'h61: e.b = 2'b00;
         8'h47, 8'h67: e.b = 2'b01;
         8'h54, 8'h74: e.b = 2'b10;
         8'h43, 8'h63: e.b = 2'b11;
         default:      e.vld = 1'b0;
      endcase
      return e;
   endfunction

endpackage

// File: rtl/fasta_feeder_char.sv
// fasta_char_decoder: combinational FASTA byte classifier.
// Ports: char_i byte in; is_base_o, is_newline_o, is_header_o, base_o.
module fasta_char_decoder
   import fasta_feeder_pkg::*;
(
   input  logic [7:0] char_i,
   output logic       is_base_o,
   output logic       is_newline_o,
   output logic       is_header_o,
   output base_t      base_o
);

   enc_t enc;

   assign enc          = encode(char_i);
   assign is_base_o    = enc.vld;
   assign base_o       = enc.b;
   assign is_newline_o = (char_i == CH_LF) || (char_i == CH_CR);
   assign is_header_o  = (char_i == CH_GT);

endmodule

// File: rtl/fasta_feeder.sv
// fasta_feeder: FASTA byte stream -> query bus + per-record aligner feed/score.
// Ports: byte in (i_vld/i_char/i_last/o_rdy), query out, aligner feed
// (o_aln_*), score strobe (o_res_*), o_err, o_done. Macro
// FASTA_FEEDER_BEST_HIT_EN enables o_best_score/o_best_id tracking.
module fasta_feeder
   import fasta_feeder_pkg::*;
#(
   parameter int MAX_QUERY_LEN = 50,
   parameter int LEN_W         = 7,
   parameter int SCORE_W       = 11,
   parameter int SCORE_BIAS    = 1024,
   parameter int DRAIN_CYCLES  = MAX_QUERY_LEN + 5,
   parameter int ID_W          = 16
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       i_local,
   input  logic                       i_vld,
   input  logic [7:0]                 i_char,
   input  logic                       i_last,
   output logic                       o_rdy,
   output logic [2*MAX_QUERY_LEN-1:0] o_query,
   output logic [LEN_W-1:0]           o_query_length,
   output logic                       o_local,
   output logic                       o_aln_rst,
   output logic                       o_aln_vld,
   output logic [1:0]                 o_aln_data,
   input  logic [SCORE_W-1:0]         i_aln_result,
   output logic                       o_res_vld,
   output logic [SCORE_W-1:0]         o_res_score,
   output logic [ID_W-1:0]            o_res_id,
   output logic [SCORE_W-1:0]         o_best_score,
   output logic [ID_W-1:0]            o_best_id,
   output logic                       o_err,
   output logic                       o_done
);

   localparam int QW      = 2 * MAX_QUERY_LEN;
   localparam int CNT_MAX = (DRAIN_CYCLES > MAX_QUERY_LEN) ?
                            DRAIN_CYCLES : MAX_QUERY_LEN;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               hdr_q, hdr_d;
   logic               last_q, last_d;
   logic [QW-1:0]      query_q, query_d;
   logic [LEN_W-1:0]   qlen_q, qlen_d;
   logic               err_q, err_d;
   logic               alnv_q, alnv_d;
   logic [1:0]         alnd_q, alnd_d;
   logic [ID_W-1:0]    id_q, id_d;
   logic               rdy_q, rdy_d;
   logic               alnr_q;
   logic               resv_q;
   logic [SCORE_W-1:0] score_q, score_d;
   logic               local_q;
   logic               done_q;

   logic               is_base, is_nl, is_hdr, is_lf, acc;
   base_t              base;
   logic               q_room;
   logic [CNT_W-1:0]   q_next;

   fasta_char_decoder u_dec (
      .char_i       (i_char),
      .is_base_o    (is_base),
      .is_newline_o (is_nl),
      .is_header_o  (is_hdr),
      .base_o       (base)
   );

   assign acc     = i_vld && rdy_q;
   assign is_lf   = (i_char == CH_LF);
   assign q_room  = cnt_q < CNT_W'(MAX_QUERY_LEN);
   assign q_next  = cnt_q + CNT_W'(is_base && q_room);
   assign score_d = i_aln_result + SCORE_W'(SCORE_BIAS);

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      hdr_d   = hdr_q;
      last_d  = last_q;
      query_d = query_q;
      qlen_d  = qlen_q;
      err_d   = err_q;
      alnv_d  = 1'b0;
      alnd_d  = alnd_q;
      id_d    = id_q;
      case (state_q)
         Q_HDR, DB_HDR: if (acc) begin
            // hdr_q: '>' seen, discarding header text until LF
            if (!hdr_q) begin
               if (is_hdr)      hdr_d = 1'b1;
               else if (!is_nl) err_d = 1'b1;
            end else if (is_lf) begin
               hdr_d   = 1'b0;
               state_d = (state_q == Q_HDR) ? Q_SEQ : DB_SEQ;
            end
            if (i_last) begin
               state_d = DONE;
               err_d   = 1'b1;
            end
         end
         Q_SEQ: if (acc) begin
            cnt_d = q_next;
            if (is_base && q_room)
               query_d[2*cnt_q +: 2] = {base[0], base[1]};
            if ((is_base && !q_room) || (!is_base && !is_nl))
               err_d = 1'b1;
            if (is_lf || i_last) begin
               cnt_d = '0;
               if (q_next == '0) begin
                  err_d   = 1'b1;
                  state_d = i_last ? DONE : Q_HDR;
               end else begin
                  qlen_d  = LEN_W'(q_next - 1'b1);
                  state_d = i_last ? DONE : DB_HDR;
               end
            end
         end
         DB_SEQ: if (acc) begin
            if (is_base) begin
               alnv_d = 1'b1;
               alnd_d = base;
            end else if (!is_nl) begin
               err_d = 1'b1;
            end
            if (is_lf || i_last) begin
               state_d = DRAIN;
               cnt_d   = '0;
               last_d  = i_last;
            end
         end
         DRAIN: begin
            if (cnt_q == CNT_W'(DRAIN_CYCLES)) state_d = REPORT;
            else                               cnt_d   = cnt_q + 1'b1;
         end
         REPORT: begin
            state_d = FLUSH;
            id_d    = id_q + 1'b1;
         end
         FLUSH:   state_d = last_q ? DONE : DB_HDR;
         DONE:    state_d = DONE;
         default: state_d = Q_HDR;
      endcase
   end

   assign rdy_d = (state_d == Q_HDR) || (state_d == Q_SEQ) ||
                  (state_d == DB_HDR) || (state_d == DB_SEQ);

   // Strobes are registered from the next state so they line up with it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= Q_HDR;
         cnt_q   <= '0;
         hdr_q   <= 1'b0;
         last_q  <= 1'b0;
         query_q <= '0;
         qlen_q  <= '0;
         err_q   <= 1'b0;
         alnv_q  <= 1'b0;
         alnd_q  <= 2'b00;
         id_q    <= '0;
         rdy_q   <= 1'b0;
         alnr_q  <= 1'b1;
         resv_q  <= 1'b0;
         score_q <= '0;
         local_q <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         hdr_q   <= hdr_d;
         last_q  <= last_d;
         query_q <= query_d;
         qlen_q  <= qlen_d;
         err_q   <= err_d;
         alnv_q  <= alnv_d;
         alnd_q  <= alnd_d;
         id_q    <= id_d;
         rdy_q   <= rdy_d;
         alnr_q  <= (state_d == FLUSH);
         resv_q  <= (state_d == REPORT);
         local_q <= i_local;
         done_q  <= (state_d == DONE);
         if (state_d == REPORT) score_q <= score_d;
      end
   end

`ifdef FASTA_FEEDER_BEST_HIT_EN
   logic [SCORE_W-1:0] best_score_q;
   logic [ID_W-1:0]    best_id_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         best_score_q <= '0;
         best_id_q    <= '0;
      end else if (state_d == REPORT && score_d > best_score_q) begin
         best_score_q <= score_d;
         best_id_q    <= id_q;
      end
   end

   assign o_best_score = best_score_q;
   assign o_best_id    = best_id_q;
`else
   assign o_best_score = '0;
   assign o_best_id    = '0;
`endif

   assign o_rdy          = rdy_q;
   assign o_query        = query_q;
   assign o_query_length = qlen_q;
   assign o_local        = local_q;
   assign o_aln_rst      = alnr_q;
   assign o_aln_vld      = alnv_q;
   assign o_aln_data     = alnd_q;
   assign o_res_vld      = resv_q;
   assign o_res_score    = score_q;
   assign o_res_id       = id_q;
   assign o_err          = err_q;
   assign o_done         = done_q;

endmodule

// File: tb/tb_fasta_feeder.sv
// tb_fasta_feeder: directed FASTA streams with hand-computed expectations.
// Covers reset, encoding, drain timing, multi-record ids, overflow, errors.
module tb_fasta_feeder;

   localparam int MQ = 50;
   localparam int LW = 7;
   localparam int SW = 11;
   localparam int IW = 16;
   localparam int D  = MQ + 5;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              i_local = 1'b0;
   logic              i_vld = 1'b0;
   logic [7:0]        i_char = 8'h00;
   logic              i_last = 1'b0;
   logic [SW-1:0]     i_aln_result = '0;
   logic              o_rdy, o_local, o_aln_rst, o_aln_vld;
   logic              o_res_vld, o_err, o_done;
   logic [2*MQ-1:0]   o_query;
   logic [LW-1:0]     o_query_length;
   logic [1:0]        o_aln_data;
   logic [SW-1:0]     o_res_score, o_best_score;
   logic [IW-1:0]     o_res_id, o_best_id;

   fasta_feeder dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .i_local        (i_local),
      .i_vld          (i_vld),
      .i_char         (i_char),
      .i_last         (i_last),
      .o_rdy          (o_rdy),
      .o_query        (o_query),
      .o_query_length (o_query_length),
      .o_local        (o_local),
      .o_aln_rst      (o_aln_rst),
      .o_aln_vld      (o_aln_vld),
      .o_aln_data     (o_aln_data),
      .i_aln_result   (i_aln_result),
      .o_res_vld      (o_res_vld),
      .o_res_score    (o_res_score),
      .o_res_id       (o_res_id),
      .o_best_score   (o_best_score),
      .o_best_id      (o_best_id),
      .o_err          (o_err),
      .o_done         (o_done)
   );

   always #5 clk = ~clk;

   int n_run = 0;
   int n_fail = 0;

   task automatic check(input string tag, input logic [127:0] got,
                        input logic [127:0] exp);
      n_run++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   int          cyc = 0;
   int          lf_cyc = 0;
   int          nacc = 0;
   int          res_cyc = -100;
   logic [1:0]  aln_q[$];
   int          sc_q[$];
   int          id_q[$];
   int          dly_q[$];
   int          bs_q[$];
   int          bi_q[$];
   int          gap_q[$];

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (i_vld && o_rdy) begin
         nacc <= nacc + 1;
         if (i_char == 8'h0A) lf_cyc <= cyc + 1;
      end
   end

   always @(negedge clk) begin
      if (o_aln_vld) aln_q.push_back(o_aln_data);
      if (o_res_vld) begin
         sc_q.push_back(int'(o_res_score));
         id_q.push_back(int'(o_res_id));
         dly_q.push_back(cyc - lf_cyc);
         bs_q.push_back(int'(o_best_score));
         bi_q.push_back(int'(o_best_id));
         res_cyc <= cyc;
      end
      if (o_aln_rst && rst_n) gap_q.push_back(cyc - res_cyc);
   end

   function automatic logic [SW-1:0] sres(input int v);
      return v[SW-1:0];
   endfunction

   function automatic logic [1:0] enc(input logic [7:0] c);
      case (c)
         8'h41:   return 2'b00;
         8'h47:   return 2'b01;
         8'h54:   return 2'b10;
         default: return 2'b11;
      endcase
   endfunction

   task automatic send(input logic [7:0] c, input logic last);
      int n = 0;
      i_vld  = 1'b1;
      i_char = c;
      i_last = last;
      while (!o_rdy && n < 500) begin
         @(negedge clk);
         n++;
      end
      if (n >= 500) check("send_timeout", 0, 1);
      @(negedge clk);
      i_vld  = 1'b0;
      i_last = 1'b0;
   endtask

   task automatic send_str(input string s, input logic last);
      for (int i = 0; i < s.len(); i++)
         send(s[i], last && (i == s.len() - 1));
   endtask

   task automatic wait_rdy();
      int n = 0;
      while (!o_rdy && n < 500) begin
         @(negedge clk);
         n++;
      end
      if (n >= 500) check("rdy_timeout", 0, 1);
   endtask

   task automatic wait_done();
      int n = 0;
      while (!o_done && n < 500) begin
         @(negedge clk);
         n++;
      end
      if (n >= 500) check("done_timeout", 0, 1);
   endtask

   task automatic do_reset();
      @(negedge clk);
      #1 rst_n = 1'b0;
      i_vld  = 1'b0;
      i_last = 1'b0;
      @(negedge clk);
      @(negedge clk);
      #2 rst_n = 1'b1;
      @(negedge clk);
   endtask

   initial begin
      #4000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int a0, r0, b0;
      string s;
      logic [2*MQ-1:0] qexp;

      // reset values
      #12;
      check("rst_rdy", o_rdy, 0);
      check("rst_aln_rst", o_aln_rst, 1);
      check("rst_aln_vld", o_aln_vld, 0);
      check("rst_query", o_query, 0);
      check("rst_qlen", o_query_length, 0);
      check("rst_res", {o_res_vld, o_res_score, o_res_id}, 0);
      check("rst_best", {o_best_score, o_best_id}, 0);
      check("rst_err_done", {o_err, o_done, o_local}, 0);
      @(negedge clk);
      #2 rst_n = 1'b1;
      i_local = 1'b1;
      @(negedge clk);
      check("post_rst_rdy", o_rdy, 1);
      check("post_rst_aln_rst", o_aln_rst, 0);
      check("local", o_local, 1);

      // basic record
      a0 = aln_q.size();
      r0 = sc_q.size();
      i_aln_result = sres(-1020);
      send_str(">q\nACGT\n>d1\nACGT\n", 1'b1);
      wait_done();
      check("t1_qlen", o_query_length, 3);
      check("t1_query", o_query, 100'h6C);
      check("t1_npulse", aln_q.size() - a0, 4);
      if (aln_q.size() >= a0 + 4) begin
         check("t1_d0", aln_q[a0],     2'b00);
         check("t1_d1", aln_q[a0 + 1], 2'b11);
         check("t1_d2", aln_q[a0 + 2], 2'b01);
         check("t1_d3", aln_q[a0 + 3], 2'b10);
      end
      check("t1_nres", sc_q.size() - r0, 1);
      if (sc_q.size() > r0) begin
         check("t1_score", sc_q[r0], 4);
         check("t1_id", id_q[r0], 0);
         check("t1_delay", dly_q[r0], D + 1);
      end
      check("t1_flush_gap", gap_q[$], 1);
      check("t1_done", o_done, 1);
      check("t1_rdy_done", o_rdy, 0);
      check("t1_err", o_err, 0);

      // three database records, best hit
      do_reset();
      r0 = sc_q.size();
      send_str(">q\nACGT\n", 1'b0);
      i_aln_result = sres(-1000);
      send_str(">a\nAC\n", 1'b0);
      wait_rdy();
      i_aln_result = sres(-900);
      send_str(">b\nG\n", 1'b0);
      wait_rdy();
      send_str(">c\nTT\n", 1'b1);
      wait_done();
      check("t2_nres", sc_q.size() - r0, 3);
      if (sc_q.size() >= r0 + 3) begin
         check("t2_id0", id_q[r0], 0);
         check("t2_id1", id_q[r0 + 1], 1);
         check("t2_id2", id_q[r0 + 2], 2);
         check("t2_sc0", sc_q[r0], 24);
         check("t2_sc1", sc_q[r0 + 1], 124);
         check("t2_sc2", sc_q[r0 + 2], 124);
`ifdef FASTA_FEEDER_BEST_HIT_EN
         check("t2_best_at0", {bs_q[r0], bi_q[r0]}, {32'd24, 32'd0});
         check("t2_best_at2", {bs_q[r0 + 2], bi_q[r0 + 2]},
               {32'd124, 32'd1});
`else
         check("t2_best_at2", {bs_q[r0 + 2], bi_q[r0 + 2]}, 0);
`endif
      end
`ifdef FASTA_FEEDER_BEST_HIT_EN
      check("t2_best", {o_best_score, o_best_id}, {11'd124, 16'd1});
`else
      check("t2_best", {o_best_score, o_best_id}, 0);
`endif
      check("t2_id_after", o_res_id, 3);

      // 52-base query overflow
      do_reset();
      s = "ACGT";
      qexp = '0;
      for (int k = 0; k < MQ; k++) begin
         qexp[2*k]     = enc(s[k % 4])[1];
         qexp[2*k + 1] = enc(s[k % 4])[0];
      end
      send_str(">q\n", 1'b0);
      for (int k = 0; k < 52; k++) send(s[k % 4], 1'b0);
      send(8'h0A, 1'b1);
      wait_done();
      check("t3_qlen", o_query_length, 49);
      check("t3_err", o_err, 1);
      check("t3_query", o_query, qexp);
      check("t3_query_lo", o_query[7:0], 8'h6C);

      // lowercase and invalid base in database line
      do_reset();
      a0 = aln_q.size();
      r0 = sc_q.size();
      i_aln_result = sres(-1024);
      send_str(">q\nAC\n>d\nagNtc\n", 1'b1);
      wait_done();
      check("t4_err", o_err, 1);
      check("t4_npulse", aln_q.size() - a0, 4);
      if (aln_q.size() >= a0 + 4) begin
         check("t4_d0", aln_q[a0],     2'b00);
         check("t4_d1", aln_q[a0 + 1], 2'b01);
         check("t4_d2", aln_q[a0 + 2], 2'b10);
         check("t4_d3", aln_q[a0 + 3], 2'b11);
      end
      if (sc_q.size() > r0) check("t4_score", sc_q[r0], 0);

      // valid held high across DRAIN
      do_reset();
      a0 = aln_q.size();
      r0 = sc_q.size();
      b0 = nacc;
      s = ">q\nA\n>d\nGT\n>e\nC\n";
      send_str(s, 1'b1);
      wait_done();
      check("t5_bytes", nacc - b0, s.len());
      check("t5_npulse", aln_q.size() - a0, 3);
      if (aln_q.size() >= a0 + 3) begin
         check("t5_d0", aln_q[a0],     2'b01);
         check("t5_d1", aln_q[a0 + 1], 2'b10);
         check("t5_d2", aln_q[a0 + 2], 2'b11);
      end
      check("t5_nres", sc_q.size() - r0, 2);
      if (sc_q.size() >= r0 + 2) check("t5_id1", id_q[r0 + 1], 1);
      check("t5_err", o_err, 0);

      // asynchronous reset in the middle of a database line
      do_reset();
      send_str(">q\nAC\n>d\nAC", 1'b0);
      #2 rst_n = 1'b0;
      #1;
      check("t6_aln_rst", o_aln_rst, 1);
      check("t6_rdy", o_rdy, 0);
      check("t6_aln_vld", o_aln_vld, 0);
      check("t6_query", {o_query, o_query_length}, 0);
      check("t6_misc", {o_err, o_done, o_res_id}, 0);
      @(negedge clk);
      #2 rst_n = 1'b1;
      @(negedge clk);
      send_str(">q\nGG\n>d\nT\n", 1'b1);
      wait_done();
      check("t6_reload_query", o_query, 100'hA);
      check("t6_reload_qlen", o_query_length, 1);
      check("t6_reload_done", o_done, 1);

      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

endmodule
